scanline_stream_buffer: RTL

//  Parametrised single-clock line buffer between a pixel producer and the framebuffer stream port (start/data/dv/ready).

---
 rtl/scanline_stream_buffer_if.sv | 30 +++
 rtl/scanline_stream_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/scanline_stream_buffer_if.sv
// Pixel-producer and framebuffer-stream signals of the scanline stream buffer.
interface scanline_stream_buffer_if #(
    parameter int DATA_W    = 15,
    parameter int NUM_BANKS = 2
);
    localparam int LEVEL_W = $clog2(NUM_BANKS + 1);

    logic [DATA_W-1:0]  iPIX_DATA;
    logic               iPIX_WRITE;
    logic               iPIX_START;
    logic               oPIX_FULL;
    logic               oPIX_OVERRUN;
    logic [LEVEL_W-1:0] oLEVEL;
    logic               oFB_START;
    logic [DATA_W-1:0]  oFB_DATA;
    logic               oFB_DATAVALID;
    logic               iFB_READY;

    // Buffer side: takes pixels, emits the framebuffer stream.
    modport slave (
        input  iPIX_DATA, iPIX_WRITE, iPIX_START, iFB_READY,
        output oPIX_FULL, oPIX_OVERRUN, oLEVEL, oFB_START, oFB_DATA, oFB_DATAVALID
    );

    // Producer and stream-sink side.
    modport master (
        output iPIX_DATA, iPIX_WRITE, iPIX_START, iFB_READY,
        input  oPIX_FULL, oPIX_OVERRUN, oLEVEL, oFB_START, oFB_DATA, oFB_DATAVALID
    );
endinterface

// File: rtl/scanline_stream_buffer.sv
// Circular multi-bank line buffer: a producer fills whole lines into banks,
// a read FSM streams each committed line LINE_REPEAT times to the framebuffer.
module scanline_stream_buffer #(
    parameter int DATA_W      = 15,
    parameter int LINE_LEN    = 640,
    parameter int NUM_BANKS   = 2,
    parameter int LINE_REPEAT = 1
) (
    input  logic                     iCLK,
    input  logic                     iRESETn,
    scanline_stream_buffer_if.slave  bus
);
    localparam int LEVEL_W = $clog2(NUM_BANKS + 1);
    localparam int IDX_W   = $clog2(LINE_LEN);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int ADDR_W  = $clog2(NUM_BANKS * LINE_LEN);
    localparam int REP_W   = 2;

    localparam logic [IDX_W-1:0]   IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(LINE_LEN - 1);
    localparam logic [BANK_W-1:0]  BANK_ZERO  = BANK_W'(0);
    localparam logic [BANK_W-1:0]  BANK_ONE   = BANK_W'(1);
    localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(NUM_BANKS - 1);
    localparam logic [REP_W-1:0]   REP_ZERO   = REP_W'(0);
    localparam logic [REP_W-1:0]   REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0]   LAST_REP   = REP_W'(LINE_REPEAT - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO = LEVEL_W'(0);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(NUM_BANKS);
    localparam logic [ADDR_W-1:0]  LINE_LEN_A = ADDR_W'(LINE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    logic [DATA_W-1:0]  r_mem [NUM_BANKS*LINE_LEN];

    state_t             r_state;
    logic [BANK_W-1:0]  r_wr_bank;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_level_q;
    logic               r_full;
    logic               r_overrun;
    logic [BANK_W-1:0]  r_rd_bank;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [REP_W-1:0]   r_rep_cnt;
    logic               r_fb_valid;
    logic               r_fb_start;
    logic [DATA_W-1:0]  r_fb_data;

    logic               w_wr_acc;
    logic               w_commit;
    logic [IDX_W-1:0]   w_wr_idx_eff;
    logic [IDX_W-1:0]   w_wr_idx_nxt;
    logic [BANK_W-1:0]  w_wr_bank_nxt;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [LEVEL_W-1:0] w_level_nxt;

    state_t             w_state_nxt;
    logic               w_xfer;
    logic               w_rd_en;
    logic               w_release;
    logic [IDX_W-1:0]   w_rd_idx_sel;
    logic [IDX_W-1:0]   w_rd_idx_nxt;
    logic [BANK_W-1:0]  w_rd_bank_nxt;
    logic [REP_W-1:0]   w_rep_nxt;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_valid_nxt;
    logic               w_start_nxt;

    // Write side: accept/drop decision, line index and bank advance on commit.
    always_comb begin
        w_wr_acc      = bus.iPIX_WRITE & ~r_full;
        w_wr_idx_eff  = bus.iPIX_START ? IDX_ZERO : r_wr_idx;
        w_commit      = w_wr_acc & (w_wr_idx_eff == LAST_IDX);
        w_wr_addr     = ADDR_W'(r_wr_bank) * LINE_LEN_A + ADDR_W'(w_wr_idx_eff);
        w_wr_idx_nxt  = r_wr_idx;
        w_wr_bank_nxt = r_wr_bank;
        if (w_commit) begin
            w_wr_idx_nxt  = IDX_ZERO;
            w_wr_bank_nxt = (r_wr_bank == LAST_BANK) ? BANK_ZERO : r_wr_bank + BANK_ONE;
        end else if (w_wr_acc) begin
            w_wr_idx_nxt  = w_wr_idx_eff + IDX_ONE;
        end else begin
            w_wr_idx_nxt  = r_wr_idx;
        end
    end

    // Level bookkeeping: commit adds a bank, release frees one, both cancel.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_commit, w_release})
            2'b10:   w_level_nxt = r_level + LEVEL_ONE;
            2'b01:   w_level_nxt = r_level - LEVEL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Read FSM next state, RAM read request and stream output next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_xfer        = r_fb_valid & bus.iFB_READY;
        w_rd_en       = 1'b0;
        w_release     = 1'b0;
        w_rd_idx_sel  = r_rd_idx;
        w_rd_idx_nxt  = r_rd_idx;
        w_rd_bank_nxt = r_rd_bank;
        w_rep_nxt     = r_rep_cnt;
        w_valid_nxt   = r_fb_valid;
        w_start_nxt   = r_fb_start;
        case (r_state)
            ST_IDLE: begin
                w_rd_idx_sel = IDX_ZERO;
                w_valid_nxt  = 1'b0;
                w_start_nxt  = 1'b0;
                // A bank committed on the previous edge gets one settle cycle
                // before the read side claims it; the delayed copy provides it.
                if ((r_level != LEVEL_ZERO) && (r_level_q != LEVEL_ZERO)) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_rd_idx_sel = IDX_ZERO;
                w_rd_en      = 1'b1;
                w_rd_idx_nxt = IDX_ZERO;
                w_valid_nxt  = 1'b1;
                w_start_nxt  = 1'b1;
                w_state_nxt  = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (r_rd_idx == LAST_IDX) begin
                        w_valid_nxt = 1'b0;
                        w_start_nxt = 1'b0;
                        if (r_rep_cnt != LAST_REP) begin
                            w_rep_nxt   = r_rep_cnt + REP_ONE;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_release     = 1'b1;
                            w_rep_nxt     = REP_ZERO;
                            w_rd_bank_nxt = (r_rd_bank == LAST_BANK) ? BANK_ZERO : r_rd_bank + BANK_ONE;
                            w_state_nxt   = ST_IDLE;
                        end
                    end else begin
                        w_rd_en      = 1'b1;
                        w_rd_idx_sel = r_rd_idx + IDX_ONE;
                        w_rd_idx_nxt = r_rd_idx + IDX_ONE;
                        w_start_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_start_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_rd_addr = ADDR_W'(r_rd_bank) * LINE_LEN_A + ADDR_W'(w_rd_idx_sel);
    end

    // Line RAM: pixel writes and the registered read that feeds oFB_DATA.
    always_ff @(posedge iCLK) begin
        if (w_wr_acc) begin
            r_mem[w_wr_addr] <= bus.iPIX_DATA;
        end
        if (w_rd_en) begin
            r_fb_data <= r_mem[w_rd_addr];
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            r_state    <= ST_IDLE;
            r_wr_bank  <= BANK_ZERO;
            r_wr_idx   <= IDX_ZERO;
            r_level    <= LEVEL_ZERO;
            r_level_q  <= LEVEL_ZERO;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
            r_rd_bank  <= BANK_ZERO;
            r_rd_idx   <= IDX_ZERO;
            r_rep_cnt  <= REP_ZERO;
            r_fb_valid <= 1'b0;
            r_fb_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_wr_idx   <= w_wr_idx_nxt;
            r_level    <= w_level_nxt;
            r_level_q  <= r_level;
            r_full     <= (w_level_nxt == FULL_LEVEL);
            r_overrun  <= r_overrun | (bus.iPIX_WRITE & r_full);
            r_rd_bank  <= w_rd_bank_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_fb_valid <= w_valid_nxt;
            r_fb_start <= w_start_nxt;
        end
    end

    assign bus.oPIX_FULL     = r_full;
    assign bus.oPIX_OVERRUN  = r_overrun;
    assign bus.oLEVEL        = r_level;
    assign bus.oFB_START     = r_fb_start;
    assign bus.oFB_DATA      = r_fb_data;
    assign bus.oFB_DATAVALID = r_fb_valid;
endmodule
